// File: rtl/coprosit_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : coprosit_regfile_sb
//  Purpose  : Posit register file with an integrated per-register scoreboard.
//             Multi-ported reads (combinational, optional same-cycle write
//             forwarding), multi-ported writeback with highest-index-port
//             priority, issue-side destination allocation, pending-write
//             count and scoreboard flush.
//  Ports    :
//    clk_i          clock
//    rst_ni         asynchronous active-low reset
//    flush_i        clear every busy bit on the next edge
//    raddr_i        per-read-port register address
//    rdata_o        per-read-port register data
//    rbusy_o        per-read-port "register has a pending write"
//    alloc_valid_i  issue requests a destination allocation
//    alloc_addr_i   destination register to allocate
//    alloc_ready_o  allocation accepted this cycle if valid
//    waddr_i        per-write-port address
//    wdata_i        per-write-port data
//    we_i           per-write-port enable
//    busy_o         registered scoreboard vector
//    pending_cnt_o  registered number of busy registers
//  Revision : 1.0  initial release
// ============================================================================
module coprosit_regfile_sb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NR_READ_PORTS  = 3,
    parameter int NR_WRITE_PORTS = 2,
    parameter int BYPASS         = 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     flush_i,
    input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0] raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic [NR_READ_PORTS-1:0]                 rbusy_o,
    input  logic                                     alloc_valid_i,
    input  logic [ADDR_WIDTH-1:0]                    alloc_addr_i,
    output logic                                     alloc_ready_o,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                we_i,
    output logic [(2**ADDR_WIDTH)-1:0]               busy_o,
    output logic [ADDR_WIDTH:0]                      pending_cnt_o
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;
    logic [NUM_REGS-1:0]                 busy_q, busy_d;
    logic [ADDR_WIDTH:0]                 cnt_q, cnt_d;
    logic                                alloc_fire;

    assign alloc_ready_o = ~busy_q[alloc_addr_i] & ~flush_i;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;

    // Scoreboard next state. Order matters: writeback clears first, then an
    // accepted allocation sets (so alloc beats a same-cycle write), and flush
    // overrides everything. Flush and alloc never coincide since flush
    // deasserts alloc_ready_o.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (we_i[j]) begin
                busy_d[waddr_i[j]] = 1'b0;
            end
        end
        if (alloc_fire) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    // Count is taken from the next busy state so both registers update
    // together and pending_cnt_o always matches popcount(busy_o).
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[k]);
        end
    end

    // Later loop iterations override earlier ones, giving the highest-index
    // write port priority on an address collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (we_i[j]) begin
                    mem_q[waddr_i[j]] <= wdata_i[j];
                end
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports. With forwarding, a same-cycle write supplies the data and
    // masks the busy flag since the value is now available; the ascending
    // port loop again lets the highest-index writer win.
    always_comb begin
        for (int i = 0; i < NR_READ_PORTS; i++) begin
            rdata_o[i] = mem_q[raddr_i[i]];
            rbusy_o[i] = busy_q[raddr_i[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                    if (we_i[j] && (waddr_i[j] == raddr_i[i])) begin
                        rdata_o[i] = wdata_i[j];
                        rbusy_o[i] = 1'b0;
                    end
                end
            end
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_coprosit_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coprosit_regfile_sb
//  Purpose  : Self-checking bench for coprosit_regfile_sb. A forwarding
//             instance and a non-forwarding instance share all inputs.
//             Expected values are queued as stimulus is driven and popped
//             when the corresponding outputs are sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coprosit_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int NREGS = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [NR-1:0][AW-1:0] raddr = '0;
    logic [NR-1:0][DW-1:0] rdata, rdata_nb;
    logic [NR-1:0]        rbusy, rbusy_nb;
    logic                 alloc_valid = 1'b0;
    logic [AW-1:0]        alloc_addr = '0;
    logic                 alloc_ready, alloc_ready_nb;
    logic [NW-1:0][AW-1:0] waddr = '0;
    logic [NW-1:0][DW-1:0] wdata = '0;
    logic [NW-1:0]        we = '0;
    logic [NREGS-1:0]     busy, busy_nb;
    logic [AW:0]          cnt, cnt_nb;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    string       nm_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    coprosit_regfile_sb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NR),
        .NR_WRITE_PORTS(NW), .BYPASS(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
        .alloc_ready_o(alloc_ready),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .busy_o(busy), .pending_cnt_o(cnt)
    );

    coprosit_regfile_sb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NR),
        .NR_WRITE_PORTS(NW), .BYPASS(0)
    ) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .raddr_i(raddr), .rdata_o(rdata_nb), .rbusy_o(rbusy_nb),
        .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
        .alloc_ready_o(alloc_ready_nb),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .busy_o(busy_nb), .pending_cnt_o(cnt_nb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        we          = '0;
    endtask

    // Record one observation to be matched against the expectation queue.
    task automatic observe(input string nm, input logic [63:0] v);
        obs_q.push_back(v);
        nm_q.push_back(nm);
    endtask

    task automatic test_reset();
        logic [63:0] e, o;
        string n;
        rst_n = 1'b0;
        raddr = {5'd31, 5'd5, 5'd0};
        idle_inputs();
        tick(); tick();
        for (int i = 0; i < NR; i++) exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);     // rbusy
        exp_q.push_back(64'd1);     // alloc_ready
        exp_q.push_back(64'd0);     // pending_cnt
        exp_q.push_back(64'd0);     // busy
        observe("rst_rdata0", 64'(rdata[0]));
        observe("rst_rdata1", 64'(rdata[1]));
        observe("rst_rdata2", 64'(rdata[2]));
        observe("rst_rbusy", 64'(rbusy));
        observe("rst_alloc_ready", 64'(alloc_ready));
        observe("rst_pending_cnt", 64'(cnt));
        observe("rst_busy", 64'(busy));
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s: got %0h expected %0h", n, o, e);
            else n_pass++;
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [63:0] e, o;
        string n;
        we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h4000_0000;
        tick();
        // Both ports hit address 9; port 1 must win, forwarded or stored.
        we = 2'b11;
        waddr[0] = 5'd9; wdata[0] = 32'h1111_1111;
        waddr[1] = 5'd9; wdata[1] = 32'h2222_2222;
        raddr = {5'd0, 5'd9, 5'd7};
        exp_q.push_back(64'h4000_0000);
        exp_q.push_back(64'h2222_2222);
        exp_q.push_back(64'h0);
        #1;
        observe("wr_read7", 64'(rdata[0]));
        observe("wr_byp_prio9", 64'(rdata[1]));
        observe("wr_nobyp_old9", 64'(rdata_nb[1]));
        tick();
        idle_inputs();
        exp_q.push_back(64'h2222_2222);
        exp_q.push_back(64'h2222_2222);
        #1;
        observe("wr_prio9", 64'(rdata[1]));
        observe("wr_prio9_nb", 64'(rdata_nb[1]));
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s: got %0h expected %0h", n, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        logic [63:0] e, o;
        string n;
        raddr[2] = 5'd3;
        we = 2'b10; waddr[1] = 5'd3; wdata[1] = 32'hDEAD_BEEF;
        exp_q.push_back(64'hDEAD_BEEF);
        exp_q.push_back(64'h0);
        #1;
        observe("byp_same_cycle", 64'(rdata[2]));
        observe("nobyp_same_cycle", 64'(rdata_nb[2]));
        tick();
        idle_inputs();
        exp_q.push_back(64'hDEAD_BEEF);
        #1;
        observe("nobyp_next_cycle", 64'(rdata_nb[2]));
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s: got %0h expected %0h", n, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_alloc();
        logic [63:0] e, o;
        string n;
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        exp_q.push_back(64'd1);
        #1;
        observe("alloc_ready_free", 64'(alloc_ready));
        tick();
        alloc_valid = 1'b0;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd1);
        observe("alloc_busy4", 64'(busy[4]));
        observe("alloc_cnt1", 64'(cnt));
        alloc_valid = 1'b1;
        raddr[0] = 5'd4;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        #1;
        observe("realloc_ready", 64'(alloc_ready));
        observe("rbusy4", 64'(rbusy[0]));
        // Writeback to the busy register: forwarding masks rbusy at once.
        alloc_valid = 1'b0;
        we = 2'b01; waddr[0] = 5'd4; wdata[0] = 32'h0000_0044;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        #1;
        observe("rbusy4_byp_masked", 64'(rbusy[0]));
        observe("rbusy4_nobyp", 64'(rbusy_nb[0]));
        tick();
        we = '0;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        observe("wr_clear_busy4", 64'(busy[4]));
        observe("wr_clear_cnt", 64'(cnt));
        // Same-cycle allocation and write: set wins, data still written.
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        we = 2'b01; waddr[0] = 5'd4; wdata[0] = 32'h0000_0055;
        tick();
        idle_inputs();
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'h55);
        #1;
        observe("alloc_wr_busy4", 64'(busy[4]));
        observe("alloc_wr_cnt", 64'(cnt));
        observe("alloc_wr_data4", 64'(rdata[0]));
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s: got %0h expected %0h", n, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [63:0] e, o;
        string n;
        for (int a = 1; a <= 3; a++) begin
            alloc_valid = 1'b1; alloc_addr = AW'(a);
            tick();
        end
        alloc_valid = 1'b0;
        // Register 4 is still busy from the previous scenario.
        exp_q.push_back(64'd4);
        exp_q.push_back(64'h1E);
        observe("pre_flush_cnt", 64'(cnt));
        observe("pre_flush_busy", 64'(busy));
        flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd6;
        exp_q.push_back(64'd0);
        #1;
        observe("flush_alloc_ready", 64'(alloc_ready));
        tick();
        idle_inputs();
        raddr = {5'd3, 5'd9, 5'd7};
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'h4000_0000);
        exp_q.push_back(64'h2222_2222);
        exp_q.push_back(64'hDEAD_BEEF);
        #1;
        observe("flush_busy", 64'(busy));
        observe("flush_cnt", 64'(cnt));
        observe("flush_mem7", 64'(rdata[0]));
        observe("flush_mem9", 64'(rdata[1]));
        observe("flush_mem3", 64'(rdata[2]));
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s: got %0h expected %0h", n, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_fill_and_reset();
        logic [63:0] e, o;
        string n;
        for (int a = 0; a < NREGS; a++) begin
            alloc_valid = 1'b1; alloc_addr = AW'(a);
            tick();
        end
        alloc_valid = 1'b0;
        exp_q.push_back(64'd32);
        exp_q.push_back(64'hFFFF_FFFF);
        exp_q.push_back(64'd0);
        observe("full_cnt", 64'(cnt));
        observe("full_busy", 64'(busy));
        alloc_valid = 1'b1; alloc_addr = 5'd17;
        #1;
        observe("full_alloc_ready", 64'(alloc_ready));
        alloc_valid = 1'b0;
        // Asynchronous reset away from any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        observe("arst_busy", 64'(busy));
        observe("arst_cnt", 64'(cnt));
        for (int a = 0; a < NREGS; a++) begin
            raddr[0] = AW'(a);
            exp_q.push_back(64'd0);
            #1;
            observe($sformatf("arst_mem%0d", a), 64'(rdata[0]));
        end
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s: got %0h expected %0h", n, o, e);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_alloc();
        test_flush();
        test_fill_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
